// File: rtl/multi_digit_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_digit_timer
// Description : N-digit BCD game timer. Counts down to all-zeros or up to
//               all-nines, one step per tick, with pause/resume, load-time
//               BCD sanitising, a timeout pulse and an expired level.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_timer #(
    parameter int NUM_DIGITS = 2,
    parameter int DW         = 4 * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          timerReconfig,
    input  logic [DW-1:0] loadValue,
    input  logic          countUp,
    input  logic          timerEnable,
    input  logic          tick,
    output logic [DW-1:0] digits,
    output logic          timeout,
    output logic          expired,
    output logic          running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_digits;
    logic            r_up;
    logic            r_timeout;
    logic            r_expired;
    logic            r_running;

    logic [DW-1:0]         w_clamped;
    logic [DW-1:0]         w_step;
    logic [DW-1:0]         w_nines;
    logic [NUM_DIGITS-1:0] w_cin;
    logic [NUM_DIGITS-1:0] w_dterm;
    logic                  w_cur_term;
    logic                  w_step_term;

    // Per-digit clamp, all-nines constant and the carry/borrow ripple chain.
    // A digit rolls over (9->0 up, 0->9 down) only when every lower digit
    // also rolled over, so the chain input is the AND of lower digit limits.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] w_ld;
        logic [3:0] w_d;

        assign w_ld = loadValue[4*i +: 4];
        assign w_d  = r_digits[4*i +: 4];

        assign w_clamped[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
        assign w_nines[4*i +: 4]   = 4'd9;
        assign w_dterm[i]          = r_up ? (w_d == 4'd9) : (w_d == 4'd0);

        if (i == 0) begin : g_first
            assign w_cin[i] = 1'b1;
        end else begin : g_rest
            assign w_cin[i] = w_cin[i-1] & w_dterm[i-1];
        end

        assign w_step[4*i +: 4] = !w_cin[i] ? w_d :
                                  r_up      ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) :
                                              ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
    end

    assign w_cur_term  = r_up ? (r_digits == w_nines) : (r_digits == '0);
    assign w_step_term = r_up ? (w_step   == w_nines) : (w_step   == '0);

    // Control FSM; reconfig overrides everything, then enable/pause, then tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_digits  <= '0;
            r_up      <= 1'b0;
            r_timeout <= 1'b0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (timerReconfig) begin
                r_state   <= S_IDLE;
                r_digits  <= w_clamped;
                r_up      <= countUp;
                r_expired <= 1'b0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (timerEnable) begin
                            if (w_cur_term) begin
                                r_state   <= S_DONE;
                                r_timeout <= 1'b1;
                                r_expired <= 1'b1;
                            end else begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!timerEnable) begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                        end else if (tick) begin
                            r_digits <= w_step;
                            if (w_step_term) begin
                                r_state   <= S_DONE;
                                r_timeout <= 1'b1;
                                r_expired <= 1'b1;
                                r_running <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        r_expired <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digits  = r_digits;
    assign timeout = r_timeout;
    assign expired = r_expired;
    assign running = r_running;

endmodule
`default_nettype wire

// File: doc/multi_digit_timer.md
# multi_digit_timer

Parametrised successor to the two-digit game timer: an N-digit BCD timer that counts down to zero or up to its all-nines ceiling, one step per external tick. It sits between the `TwoSecondTimer` pulse outputs and the per-digit `decoder_4to7` instances in the Orion top level, and it is driven by the game controller. New relative to the two-digit version: a configurable digit count, a selectable count direction, pause/resume with the value held, sanitising of invalid BCD at load, and separate `timeout` (pulse) and `expired` (level) outputs.

## Interface
- `NUM_DIGITS`, 2: number of BCD digits. Legal range is 1..8.
- `DW`, 4*`NUM_DIGITS`: derived digit-bus width. Not overridden.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `timerReconfig` in 1: load request; sampled every cycle.
- `loadValue` in `DW`: BCD load value; digit 0 sits in bits [3:0] (ones).
- `countUp` in 1: direction, latched only on `timerReconfig`. 1 = up, 0 = down.
- `timerEnable` in 1: level input. 1 = run, 0 = pause.
- `tick` in 1: single-cycle step strobe from `TwoSecondTimer`.
- `digits` out `DW`: current BCD value, registered.
- `timeout` out 1: one-cycle pulse when the terminal value is reached.
- `expired` out 1: high in DONE.
- `running` out 1: high in RUN.

## Operation
- Terminal value:
  - down mode: all digits 0.
  - up mode: all digits 9.
- States and transitions:
  - IDLE: value held.
    - `timerEnable`=1 and value not terminal → RUN.
    - `timerEnable`=1 and value already terminal → DONE, and `timeout` pulses.
  - RUN: `running`=1.
    - `timerEnable`=0 → IDLE, value held (pause).
    - `tick`=1 → step by 1, BCD-correct:
      - down: 0 becomes 9 with a borrow into the next digit.
      - up: 9 becomes 0 with a carry into the next digit.
    - If the stepped value is terminal → DONE, and `timeout` pulses.
  - DONE: `expired`=1, value frozen at terminal; `tick` and `timerEnable` are ignored.
- `timerReconfig`=1, in any state:
  - load `loadValue`; any digit > 9 is clamped to 9;
  - latch `countUp`;
  - go to IDLE;
  - clear `expired`;
  - no `timeout` pulse.
- Priority: `timerReconfig` > enable/pause > `tick`.
  - A tick in the same cycle as `timerEnable`=0 is dropped.
  - A tick in the cycle the FSM moves IDLE→RUN is dropped; ticks count only from RUN.
- No wrap past terminal; the value never under- or over-flows.
- Reset (`rst`=0, asynchronous):
  - state IDLE, `digits`=0, direction down;
  - `timeout`=0, `expired`=0, `running`=0.
- Reset is allowed mid-count; there is no resume after reset.

## Timing
- All outputs are registered.
- `tick` sampled high at edge k → `digits` updated after edge k; visible in cycle k+1.
- `timeout` is high for exactly the one cycle in which `digits` first shows the terminal value. `expired` rises in that same cycle.
- `timerReconfig` at edge k → loaded `digits`, IDLE and `expired`=0 from cycle k+1.
- Enable/pause takes one cycle: `running` follows `timerEnable` one edge later.
- Back-to-back ticks, one every cycle, are supported; each produces one step.
- `rst` asserted forces outputs to their reset values immediately (asynchronous). Deassertion is synchronised externally.

## Test plan
1. Reset, then reconfig `loadValue`=0x15, down, enable, 15 ticks → `digits` steps 15,14,…,10,09,…,00. `timeout` is a single pulse in the cycle `digits`=00; `expired`=1 and `running`=0 afterwards. 3 further ticks leave `digits`=00.
2. `NUM_DIGITS`=3: load 0x100, down, 1 tick → 0x099 (borrow across two digits). Load 0x998, up, 1 tick → 0x999, `timeout` pulses, DONE.
3. Pause/resume: load 0x10, run 3 ticks (0x07), drop `timerEnable` with a tick in the same cycle → `digits` stays 0x07 and `running`=0. Re-enable, 1 tick → 0x06.
4. Edge loads:
   - load 0x00 down, enable → DONE next cycle, one `timeout`, no tick needed;
   - load 0xAF → `digits`=0x99.
5. `timerReconfig` asserted together with a tick while in RUN → loaded value appears and the tick is ignored. Reconfig while in DONE → `expired` clears and no `timeout` is generated.
6. Assert `rst` mid-count at a non-edge time → `digits`=0 and all flags 0 immediately. After release, `timerEnable`=1 with no reconfig → DONE, since 0 is terminal in down mode.
